// File: rtl/alu_packet_parser.sv
// alu_packet_parser: turns a UART-RX byte stream of framed ALU packets into
//   operand words (opcode, 32-bit operand, first/last flags) for a downstream ALU.
// Latency: a word is presented one cycle after its completing byte is accepted.
// Backpressure: while a word waits for op_ready_i the parser holds it and drops
//   rx_ready_o; every other state accepts one byte per cycle.
// Ports:
//   clk, rst           - sole clock; synchronous active-high reset
//   rx_valid_i/rx_data_i/rx_ready_o - byte input handshake
//   op_valid_o/op_ready_i           - word output handshake
//   opcode_o, operand_o, first_o, last_o - word payload (all registered)
//   err_o              - one-cycle pulse when a packet is rejected or aborted
// Build option: define ALU_PARSER_TIMEOUT_EN to abort a packet after
//   TIMEOUT_CYCLES idle cycles mid-packet; without it TIMEOUT_CYCLES is unused.
module alu_packet_parser #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [7:0]  opcode_o,
  output logic [31:0] operand_o,
  output logic        first_o,
  output logic        last_o,
  output logic        err_o
);

  localparam logic [7:0] OPC_ECHO = 8'hEC;
  localparam logic [7:0] OPC_ADD  = 8'hAD;
  localparam logic [7:0] OPC_MUL  = 8'hAC;
  localparam logic [7:0] OPC_DIV  = 8'hD1;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_PAYLOAD,
    S_EMIT,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic        r_rx_ready;
  logic        r_op_valid;
  logic        r_first_o;
  logic        r_last_o;
  logic        r_err;
  logic [7:0]  r_opcode;
  logic [7:0]  r_len_lo;
  logic [31:0] r_operand;
  logic [23:0] r_acc;            // low three bytes of an arithmetic word
  logic [1:0]  r_byte_idx;       // byte position within an arithmetic word
  logic [15:0] r_remain;         // payload bytes still to be accepted
  logic        r_first_pending;  // next emitted word is the packet's first
`ifdef ALU_PARSER_TIMEOUT_EN
  logic [23:0] r_to_cnt;
`endif

  logic        w_accept;
  logic        w_is_echo;
  logic        w_is_arith;
  logic        w_word_done;
  logic [15:0] w_len;
  logic [15:0] w_remain_dec;
  logic [31:0] w_word;

  assign w_accept     = rx_valid_i & r_rx_ready;
  assign w_is_echo    = (r_opcode == OPC_ECHO);
  assign w_is_arith   = (r_opcode == OPC_ADD) | (r_opcode == OPC_MUL) | (r_opcode == OPC_DIV);
  assign w_len        = {rx_data_i, r_len_lo};
  assign w_remain_dec = r_remain - 16'd1;
  // Echo completes a word on every byte; arithmetic on the fourth byte.
  assign w_word_done  = w_is_echo | (r_byte_idx == 2'd3);
  assign w_word       = w_is_echo ? {24'h0, rx_data_i} : {rx_data_i, r_acc};

  assign rx_ready_o = r_rx_ready;
  assign op_valid_o = r_op_valid;
  assign opcode_o   = r_opcode;
  assign operand_o  = r_operand;
  assign first_o    = r_first_o;
  assign last_o     = r_last_o;
  assign err_o      = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_OPCODE;
      r_rx_ready      <= 1'b0;
      r_op_valid      <= 1'b0;
      r_first_o       <= 1'b0;
      r_last_o        <= 1'b0;
      r_err           <= 1'b0;
      r_opcode        <= 8'h00;
      r_len_lo        <= 8'h00;
      r_operand       <= 32'h0;
      r_acc           <= 24'h0;
      r_byte_idx      <= 2'd0;
      r_remain        <= 16'h0;
      r_first_pending <= 1'b0;
`ifdef ALU_PARSER_TIMEOUT_EN
      r_to_cnt        <= 24'h0;
`endif
    end else begin
      r_err      <= 1'b0;
      r_rx_ready <= 1'b1;

      case (r_state)
        S_OPCODE: begin
          if (w_accept) begin
            r_opcode <= rx_data_i;
            r_state  <= S_RSVD;
          end
        end

        S_RSVD: begin
          if (w_accept) r_state <= S_LEN_LO;
        end

        S_LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= rx_data_i;
            r_state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (w_accept) begin
            r_remain        <= w_len - 16'd4;
            r_first_pending <= 1'b1;
            r_byte_idx      <= 2'd0;
            if (w_len < 16'd4) begin
              r_err   <= 1'b1;
              r_state <= S_OPCODE;
            end else if (w_len == 16'd4) begin
              r_state <= S_OPCODE;
            end else if (!(w_is_echo | w_is_arith) ||
                         (w_is_arith && (w_len[1:0] != 2'b00))) begin
              // (len-4) mod 4 equals len mod 4, so the low bits decide alignment
              r_err   <= 1'b1;
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          if (w_accept) begin
            r_remain   <= w_remain_dec;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_acc[7:0]   <= rx_data_i;
              2'd1:    r_acc[15:8]  <= rx_data_i;
              2'd2:    r_acc[23:16] <= rx_data_i;
              default: ;
            endcase
            if (w_word_done) begin
              r_operand       <= w_word;
              r_op_valid      <= 1'b1;
              r_first_o       <= r_first_pending;
              r_last_o        <= (r_remain == 16'd1);
              r_first_pending <= 1'b0;
              r_rx_ready      <= 1'b0;
              r_state         <= S_EMIT;
            end
          end
        end

        S_EMIT: begin
          if (op_ready_i) begin
            r_op_valid <= 1'b0;
            r_first_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_state    <= (r_remain == 16'h0) ? S_OPCODE : S_PAYLOAD;
          end else begin
            r_rx_ready <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (w_accept) begin
            r_remain <= w_remain_dec;
            if (r_remain == 16'd1) r_state <= S_OPCODE;
          end
        end

        default: r_state <= S_OPCODE;
      endcase

`ifdef ALU_PARSER_TIMEOUT_EN
      // Idle time only counts while a packet is in flight and the parser is
      // waiting on the byte source; a stalled ALU never triggers an abort.
      if ((r_state == S_OPCODE) || (r_state == S_EMIT) || w_accept) begin
        r_to_cnt <= 24'h0;
      end else if ((r_to_cnt + 24'd1) >= TIMEOUT_CYCLES) begin
        r_to_cnt <= 24'h0;
        r_err    <= 1'b1;
        r_state  <= S_OPCODE;
      end else begin
        r_to_cnt <= r_to_cnt + 24'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_packet_parser.sv
module tb_alu_packet_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        op_valid_o;
  logic        op_ready_i;
  logic [7:0]  opcode_o;
  logic [31:0] operand_o;
  logic        first_o;
  logic        last_o;
  logic        err_o;

  always #5 clk = ~clk;

  alu_packet_parser #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .rx_ready_o (rx_ready_o),
    .op_valid_o (op_valid_o),
    .op_ready_i (op_ready_i),
    .opcode_o   (opcode_o),
    .operand_o  (operand_o),
    .first_o    (first_o),
    .last_o     (last_o),
    .err_o      (err_o)
  );

  typedef struct packed {
    logic [7:0]  opc;
    logic [31:0] opd;
    logic        first;
    logic        last;
  } word_t;

  word_t      got_q[$];
  word_t      exp_q[$];
  logic [7:0] pkt[$];
  int         got_err = 0;
  int         exp_err = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         since_rst = 0;
  int         rdy_mode = 0;   // 0 manual, 1 always ready, 2 random
  bit         prev_stall = 0;
  word_t      prev_word;

  // Consumer-side ready generator.
  initial begin
    op_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) op_ready_i = 1'b1;
      else if (rdy_mode == 2) op_ready_i = 1'($urandom_range(0, 1));
    end
  end

  always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;

  // Monitor: records handshaken words and error pulses, checks hold/ready rules.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      w = {opcode_o, operand_o, first_o, last_o};
      if (prev_stall) begin
        n_cmp++;
        if (op_valid_o !== 1'b1 || w !== prev_word) begin
          n_fail++;
          $display("FAIL hold_stable got v=%b %h required v=1 %h", op_valid_o, w, prev_word);
        end
      end
      if (since_rst >= 1) begin
        n_cmp++;
        if (rx_ready_o !== !op_valid_o) begin
          n_fail++;
          $display("FAIL ready_vs_valid got rx_ready=%b op_valid=%b required opposite", rx_ready_o, op_valid_o);
        end
      end
      if (op_valid_o && op_ready_i) got_q.push_back(w);
      if (err_o) got_err++;
      prev_stall = op_valid_o && !op_ready_i;
      prev_word  = w;
    end
  end

  task automatic clr();
    got_q.delete(); exp_q.delete(); got_err = 0; exp_err = 0;
  endtask

  task automatic set_pkt(input logic [95:0] bytes, input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  // Reference model: derives the words/errors a whole packet should produce.
  task automatic model_pkt();
    int len, n; logic [7:0] opc; bit arith; word_t w;
    opc   = pkt[0];
    len   = int'({pkt[3], pkt[2]});
    n     = len - 4;
    arith = (opc == 8'hAD) || (opc == 8'hAC) || (opc == 8'hD1);
    if (len < 4) exp_err++;
    else if (len == 4) begin end
    else if (!(arith || opc == 8'hEC) || (arith && (n % 4) != 0)) exp_err++;
    else if (!arith) begin
      for (int i = 0; i < n; i++) begin
        w.opc = opc; w.opd = {24'h0, pkt[4+i]}; w.first = (i == 0); w.last = (i == n-1);
        exp_q.push_back(w);
      end
    end else begin
      for (int i = 0; i < n/4; i++) begin
        w.opc = opc;
        w.opd = {pkt[4+4*i+3], pkt[4+4*i+2], pkt[4+4*i+1], pkt[4+4*i]};
        w.first = (i == 0); w.last = (i == n/4-1);
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic gen_pkt();
    int sel, r, len; logic [7:0] opc;
    sel = $urandom_range(0, 4);
    case (sel)
      0: opc = 8'hEC;
      1: opc = 8'hAD;
      2: opc = 8'hAC;
      3: opc = 8'hD1;
      default: opc = 8'($urandom_range(16, 79));
    endcase
    r = $urandom_range(0, 9);
    if (r == 0) len = $urandom_range(0, 3);
    else if (r < 3) len = $urandom_range(4, 19);
    else if (sel == 0) len = $urandom_range(4, 10);
    else len = 4 + 4 * $urandom_range(0, 3);
    if (sel == 4 && len == 4) len = 6;
    pkt.delete();
    pkt.push_back(opc); pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]); pkt.push_back(len[15:8]);
    for (int i = 4; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap);
    bit acc;
    rx_valid_i = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid_i = 1'b1; rx_data_i = b; acc = 1'b0;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk); acc = rx_ready_o;
      @(posedge clk); #1;
    end
    rx_valid_i = 1'b0;
    n_cmp++;
    if (!acc) begin n_fail++; $display("FAIL rx_accept byte %h got not accepted required accepted", b); end
  endtask

  task automatic send_pkt(input int max_gap);
    for (int i = 0; i < pkt.size(); i++) drive_byte(pkt[i], $urandom_range(0, max_gap));
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'hAD; op_ready_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++;
    if ({op_valid_o, first_o, last_o, err_o, rx_ready_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b required 00000", {op_valid_o, first_o, last_o, err_o, rx_ready_o});
    end
    n_cmp++;
    if (operand_o !== 32'h0 || opcode_o !== 8'h00) begin
      n_fail++; $display("FAIL reset_data got opd=%h opc=%h required 0", operand_o, opcode_o);
    end
    rx_valid_i = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (rx_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b required 1", rx_ready_o); end
    n_cmp++;
    if (opcode_o !== 8'h00) begin n_fail++; $display("FAIL reset_no_accept got opc=%h required 00", opcode_o); end
  endtask

  task automatic test_add();
    word_t w;
    clr(); rdy_mode = 1;
    set_pkt(96'hAD_00_0C_00_01_00_00_00_02_00_00_00, 12);
    w = {8'hAD, 32'h1, 1'b1, 1'b0}; exp_q.push_back(w);
    w = {8'hAD, 32'h2, 1'b0, 1'b1}; exp_q.push_back(w);
    send_pkt(0);
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL add_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL add_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_err !== 0) begin n_fail++; $display("FAIL add_err got %0d required 0", got_err); end
  endtask

  task automatic test_echo_stall();
    clr(); rdy_mode = 0; op_ready_i = 1'b0;
    set_pkt(96'hEC_00_06_00_41_42, 6); model_pkt();
    for (int i = 0; i < 5; i++) drive_byte(pkt[i], 0);
    n_cmp++;
    if ({op_valid_o, first_o, last_o} !== 3'b110 || operand_o !== 32'h41 || opcode_o !== 8'hEC) begin
      n_fail++; $display("FAIL echo_latency got v/f/l=%b opd=%h opc=%h required 110 41 EC", {op_valid_o, first_o, last_o}, operand_o, opcode_o);
    end
    rx_valid_i = 1'b1; rx_data_i = 8'h42;
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if (op_valid_o !== 1'b1 || operand_o !== 32'h41 || rx_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL echo_stall got v=%b opd=%h rdy=%b required 1 41 0", op_valid_o, operand_o, rx_ready_o);
      end
    end
    rx_valid_i = 1'b0; rdy_mode = 1;
    drive_byte(8'h42, 0);
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL echo_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL echo_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_unknown_then_mul();
    clr(); rdy_mode = 1;
    set_pkt(96'h55_00_07_00_AA_BB_CC, 7); model_pkt(); send_pkt(1);
    set_pkt(96'hAC_00_08_00_03_00_00_00, 8); model_pkt(); send_pkt(1);
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL unk_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL unk_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_err !== exp_err) begin n_fail++; $display("FAIL unk_err got %0d required %0d", got_err, exp_err); end
  endtask

  task automatic test_bad_len();
    clr(); rdy_mode = 1;
    set_pkt(96'hAD_00_07_00_11_22_33, 7); model_pkt();
    for (int i = 0; i < 4; i++) drive_byte(pkt[i], 0);
    n_cmp++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL badlen_pulse got %b required 1", err_o); end
    drive_byte(pkt[4], 0);
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL badlen_pulse_width got %b required 0", err_o); end
    drive_byte(pkt[5], 0); drive_byte(pkt[6], 0);
    set_pkt(96'hEC_00_05_00_99, 5); model_pkt(); send_pkt(0);
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL badlen_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badlen_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_err !== exp_err) begin n_fail++; $display("FAIL badlen_err got %0d required %0d", got_err, exp_err); end
  endtask

  task automatic test_reset_mid();
    clr(); rdy_mode = 0; op_ready_i = 1'b0;
    // Reset while a word is waiting, with a simultaneous ready: no handshake, no error.
    set_pkt(96'hEC_00_05_00_33, 5); send_pkt(0);
    op_ready_i = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (op_valid_o !== 1'b0 || err_o !== 1'b0 || rx_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_emit got v=%b err=%b rdy=%b required 0 0 0", op_valid_o, err_o, rx_ready_o);
    end
    rst = 1'b0; op_ready_i = 1'b0; rdy_mode = 1;
    set_pkt(96'hAD_00_0C_00_01_00, 6); send_pkt(0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (op_valid_o !== 1'b0 || opcode_o !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid got v=%b opc=%h required 0 00", op_valid_o, opcode_o);
    end
    rst = 1'b0;
    set_pkt(96'hAD_00_0C_00_78_56_34_12_EF_BE_AD_DE, 12); model_pkt(); send_pkt(1);
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_err !== 0) begin n_fail++; $display("FAIL rstmid_err got %0d required 0", got_err); end
  endtask

  task automatic test_timeout();
    clr(); rdy_mode = 1;
    set_pkt(96'hD1_00_0C_00, 4); send_pkt(0);
    repeat (20) @(posedge clk); #1;
`ifdef ALU_PARSER_TIMEOUT_EN
    n_cmp++; if (got_err !== 1) begin n_fail++; $display("FAIL timeout_err got %0d required 1", got_err); end
`else
    n_cmp++; if (got_err !== 0) begin n_fail++; $display("FAIL no_timeout_err got %0d required 0", got_err); end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
`endif
    clr();
    set_pkt(96'hEC_00_05_00_07, 5); model_pkt(); send_pkt(0);
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL timeout_next_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL timeout_next_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    clr(); rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin gen_pkt(); model_pkt(); send_pkt(2); end
    rdy_mode = 1;
    for (int k = 0; k < 3000 && got_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_word%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++; if (got_err !== exp_err) begin n_fail++; $display("FAIL rand_err got %0d required %0d", got_err, exp_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00;
    test_reset();
    test_add();
    test_echo_stall();
    test_unknown_then_mul();
    test_bad_len();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
